// File: rtl/auction_host_seq.sv
// ---------------------------------------------------------------------------
// auction_host_seq
//   Host-side command sequencer for the 3-bidder auction controller.
//   One accepted round request runs the whole round on the controller's C_*
//   port:
//     1. load the three balances, the bidder mask, the timer and the bid
//        charge, then Lock with the key;
//     2. hold C_start for the round length;
//     3. wait for roundOver and capture maxBid;
//     4. Unlock with the same key;
//     5. return a one-cycle response.
//
//   Op handshake: in an issue cycle the sequencer looks at `ready`. When
//   ready=1 the op is registered onto C_op/C_data for exactly one cycle. One
//   NoOp check cycle follows, and `err` is sampled at the end of that check
//   cycle. When no error is reported, that same check cycle is also the issue
//   cycle for the next op. A clean ready=1 flow therefore shows op,NoOp,op,NoOp.
//
// Ports
//   clk, reset_n        clock (rising edge), synchronous active-low reset
//   req_valid/req_ready round request handshake; req_ready=1 only in IDLE
//   req_x/y/z_bal       balances for LoadX/LoadY/LoadZ
//   req_mask            bidder enable mask (zero-extended onto C_data)
//   req_timer           SetTimer operand
//   req_bid_cost        BidCharge operand
//   req_key             Lock/Unlock key
//   req_round_len       C_start high time in cycles (0 treated as 1)
//   C_op/C_data/C_start command port to the auction controller
//   ready, err          controller op acceptance and error code
//   roundOver, maxBid   controller round result
//   rsp_valid           one-cycle response pulse
//   rsp_status          00 ok, 01 controller err, 10 result timeout,
//                       11 ready timeout
//   rsp_err             err value behind status 01
//   rsp_max_bid         captured maxBid (0 when none was captured)
//   busy                1 whenever a request is in progress
// ---------------------------------------------------------------------------
module auction_host_seq #(
   parameter int READY_TIMEOUT  = 16,
   parameter int RESULT_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_x_bal,
   input  logic [31:0] req_y_bal,
   input  logic [31:0] req_z_bal,
   input  logic [2:0]  req_mask,
   input  logic [31:0] req_timer,
   input  logic [31:0] req_bid_cost,
   input  logic [31:0] req_key,
   input  logic [15:0] req_round_len,
   output logic [3:0]  C_op,
   output logic [31:0] C_data,
   output logic        C_start,
   input  logic        ready,
   input  logic [1:0]  err,
   input  logic        roundOver,
   input  logic [31:0] maxBid,
   output logic        rsp_valid,
   output logic [1:0]  rsp_status,
   output logic [1:0]  rsp_err,
   output logic [31:0] rsp_max_bid,
   output logic        busy
);

   typedef enum logic [3:0] {
      OP_NOP    = 4'd0,
      OP_UNLOCK = 4'd1,
      OP_LOCK   = 4'd2,
      OP_LOAD_X = 4'd3,
      OP_LOAD_Y = 4'd4,
      OP_LOAD_Z = 4'd5,
      OP_MASK   = 4'd6,
      OP_TIMER  = 4'd7,
      OP_CHARGE = 4'd8
   } op_e;

   typedef enum logic [1:0] {
      STAT_OK       = 2'b00,
      STAT_CTRL_ERR = 2'b01,
      STAT_RES_TO   = 2'b10,
      STAT_RDY_TO   = 2'b11
   } status_e;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ISSUE,     // waiting for ready, NoOp on the bus
      ST_DRIVE,     // op on the bus for this single cycle
      ST_CHECK,     // NoOp; err sampled at its end, next op may issue
      ST_ROUND,
      ST_WAIT_RES,
      ST_UNLOCK,    // waiting for ready to issue Unlock
      ST_UDRIVE,
      ST_UCHECK,
      ST_RESP
   } state_e;

   localparam int             RDY_W    = $clog2(READY_TIMEOUT + 1);
   localparam int             RES_W    = $clog2(RESULT_TIMEOUT + 1);
   localparam logic [RDY_W-1:0] RDY_LAST = RDY_W'(READY_TIMEOUT - 1);
   localparam logic [RES_W-1:0] RES_LAST = RES_W'(RESULT_TIMEOUT - 1);
   localparam logic [2:0]     LAST_OP  = 3'd6;

   state_e           state;
   status_e          status_q;
   logic [2:0]       op_idx;
   logic [RDY_W-1:0] rdy_cnt;
   logic [RES_W-1:0] res_cnt;
   logic [15:0]      round_cnt;
   logic [31:0]      bid_q;

   // Request fields, frozen at accept
   logic [31:0] x_q, y_q, z_q, timer_q, cost_q, key_q;
   logic [2:0]  mask_q;
   logic [15:0] len_q;

   // Op selected for the current issue slot. A check cycle doubles as the
   // issue slot of the following op, so it looks one entry ahead.
   logic [2:0]  issue_idx;
   op_e         issue_op;
   logic [31:0] issue_data;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and a latch cannot be inferred.
      issue_idx  = (state == ST_CHECK) ? op_idx + 3'd1 : op_idx;
      issue_op   = OP_NOP;
      issue_data = '0;
      case (issue_idx)
         3'd0: begin issue_op = OP_LOAD_X; issue_data = x_q;              end
         3'd1: begin issue_op = OP_LOAD_Y; issue_data = y_q;              end
         3'd2: begin issue_op = OP_LOAD_Z; issue_data = z_q;              end
         3'd3: begin issue_op = OP_MASK;   issue_data = {29'd0, mask_q};  end
         3'd4: begin issue_op = OP_TIMER;  issue_data = timer_q;          end
         3'd5: begin issue_op = OP_CHARGE; issue_data = cost_q;           end
         3'd6: begin issue_op = OP_LOCK;   issue_data = key_q;            end
         default: ;
      endcase
   end

   // NOTE: all state and registered outputs use non-blocking assignments so
   // every register samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         status_q    <= STAT_OK;
         op_idx      <= '0;
         rdy_cnt     <= '0;
         res_cnt     <= '0;
         round_cnt   <= '0;
         bid_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         timer_q     <= '0;
         cost_q      <= '0;
         key_q       <= '0;
         mask_q      <= '0;
         len_q       <= '0;
         C_op        <= OP_NOP;
         C_data      <= '0;
         C_start     <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_status  <= STAT_OK;
         rsp_err     <= '0;
         rsp_max_bid <= '0;
         busy        <= 1'b0;
         req_ready   <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  x_q       <= req_x_bal;
                  y_q       <= req_y_bal;
                  z_q       <= req_z_bal;
                  mask_q    <= req_mask;
                  timer_q   <= req_timer;
                  cost_q    <= req_bid_cost;
                  key_q     <= req_key;
                  len_q     <= req_round_len;
                  op_idx    <= '0;
                  rdy_cnt   <= '0;
                  res_cnt   <= '0;
                  bid_q     <= '0;
                  status_q  <= STAT_OK;
                  busy      <= 1'b1;
                  req_ready <= 1'b0;
                  state     <= ST_ISSUE;
               end
            end

            ST_ISSUE, ST_CHECK: begin
               if (state == ST_CHECK && err != 2'b00) begin
                  // Failed op: report it at once, no round and no Unlock
                  rsp_valid   <= 1'b1;
                  rsp_status  <= STAT_CTRL_ERR;
                  rsp_err     <= err;
                  rsp_max_bid <= bid_q;
                  state       <= ST_RESP;
               end else if (state == ST_CHECK && op_idx == LAST_OP) begin
                  C_start   <= 1'b1;
                  round_cnt <= (len_q == 16'd0) ? 16'd0 : len_q - 16'd1;
                  state     <= ST_ROUND;
               end else if (ready) begin
                  C_op    <= issue_op;
                  C_data  <= issue_data;
                  op_idx  <= issue_idx;
                  rdy_cnt <= '0;
                  state   <= ST_DRIVE;
               end else if (rdy_cnt == RDY_LAST) begin
                  rsp_valid   <= 1'b1;
                  rsp_status  <= STAT_RDY_TO;
                  rsp_err     <= '0;
                  rsp_max_bid <= bid_q;
                  state       <= ST_RESP;
               end else begin
                  op_idx  <= issue_idx;
                  rdy_cnt <= rdy_cnt + RDY_W'(1);
                  state   <= ST_ISSUE;
               end
            end

            ST_DRIVE: begin
               C_op   <= OP_NOP;
               C_data <= '0;
               state  <= ST_CHECK;
            end

            ST_ROUND: begin
               if (round_cnt == 16'd0) begin
                  C_start <= 1'b0;
                  res_cnt <= '0;
                  state   <= ST_WAIT_RES;
               end else begin
                  round_cnt <= round_cnt - 16'd1;
               end
            end

            ST_WAIT_RES: begin
               // A timeout still proceeds to Unlock so the controller is
               // never left locked.
               if (roundOver) begin
                  bid_q   <= maxBid;
                  rdy_cnt <= '0;
                  state   <= ST_UNLOCK;
               end else if (res_cnt == RES_LAST) begin
                  status_q <= STAT_RES_TO;
                  rdy_cnt  <= '0;
                  state    <= ST_UNLOCK;
               end else begin
                  res_cnt <= res_cnt + RES_W'(1);
               end
            end

            ST_UNLOCK: begin
               if (ready) begin
                  C_op    <= OP_UNLOCK;
                  C_data  <= key_q;
                  rdy_cnt <= '0;
                  state   <= ST_UDRIVE;
               end else if (rdy_cnt == RDY_LAST) begin
                  // An earlier result timeout keeps priority over this one
                  rsp_valid   <= 1'b1;
                  rsp_status  <= (status_q == STAT_OK) ? STAT_RDY_TO : status_q;
                  rsp_err     <= '0;
                  rsp_max_bid <= bid_q;
                  state       <= ST_RESP;
               end else begin
                  rdy_cnt <= rdy_cnt + RDY_W'(1);
               end
            end

            ST_UDRIVE: begin
               C_op   <= OP_NOP;
               C_data <= '0;
               state  <= ST_UCHECK;
            end

            ST_UCHECK: begin
               rsp_valid   <= 1'b1;
               rsp_max_bid <= bid_q;
               if (err != 2'b00 && status_q == STAT_OK) begin
                  rsp_status <= STAT_CTRL_ERR;
                  rsp_err    <= err;
               end else begin
                  rsp_status <= status_q;
                  rsp_err    <= '0;
               end
               state <= ST_RESP;
            end

            ST_RESP: begin
               rsp_valid   <= 1'b0;
               rsp_status  <= STAT_OK;
               rsp_err     <= '0;
               rsp_max_bid <= '0;
               busy        <= 1'b0;
               req_ready   <= 1'b1;
               state       <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_auction_host_seq.sv
// ---------------------------------------------------------------------------
// tb_auction_host_seq
//   Directed bench for auction_host_seq. Inputs are driven and outputs are
//   sampled on the falling edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_auction_host_seq;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_x_bal, req_y_bal, req_z_bal;
   logic [2:0]  req_mask;
   logic [31:0] req_timer, req_bid_cost, req_key;
   logic [15:0] req_round_len;
   logic [3:0]  C_op;
   logic [31:0] C_data;
   logic        C_start;
   logic        ready;
   logic [1:0]  err;
   logic        roundOver;
   logic [31:0] maxBid;
   logic        rsp_valid;
   logic [1:0]  rsp_status;
   logic [1:0]  rsp_err;
   logic [31:0] rsp_max_bid;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   auction_host_seq dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_x_bal     (req_x_bal),
      .req_y_bal     (req_y_bal),
      .req_z_bal     (req_z_bal),
      .req_mask      (req_mask),
      .req_timer     (req_timer),
      .req_bid_cost  (req_bid_cost),
      .req_key       (req_key),
      .req_round_len (req_round_len),
      .C_op          (C_op),
      .C_data        (C_data),
      .C_start       (C_start),
      .ready         (ready),
      .err           (err),
      .roundOver     (roundOver),
      .maxBid        (maxBid),
      .rsp_valid     (rsp_valid),
      .rsp_status    (rsp_status),
      .rsp_err       (rsp_err),
      .rsp_max_bid   (rsp_max_bid),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic present(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                          input logic [2:0] m, input logic [31:0] t, input logic [31:0] c,
                          input logic [31:0] k, input logic [15:0] len);
      req_x_bal     = x;
      req_y_bal     = y;
      req_z_bal     = z;
      req_mask      = m;
      req_timer     = t;
      req_bid_cost  = c;
      req_key       = k;
      req_round_len = len;
   endtask

   // Called at the sample point of the first ISSUE cycle (one edge after
   // accept). Checks the first n_ops ops, each followed by one NoOp cycle.
   task automatic expect_ops(input string tag, input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] z, input logic [2:0] m, input logic [31:0] t,
                             input logic [31:0] c, input logic [31:0] k, input int n_ops);
      logic [3:0]  codes [7];
      logic [31:0] data  [7];
      codes = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2};
      data  = '{x, y, z, {29'd0, m}, t, c, k};
      for (int i = 0; i < n_ops; i++) begin
         step();
         check($sformatf("%s op%0d code", tag, i), C_op, codes[i]);
         check($sformatf("%s op%0d data", tag, i), C_data, data[i]);
         step();
         check($sformatf("%s op%0d noop", tag, i), C_op, 4'd0);
         check($sformatf("%s op%0d noop data", tag, i), C_data, 32'd0);
      end
   endtask

   // C_start must be high for exactly n cycles with NoOp, then fall.
   // Returns at the sample point of the first cycle after the fall.
   task automatic expect_round(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         step();
         check($sformatf("%s start%0d", tag, i), C_start, 1'b1);
         check($sformatf("%s start%0d op", tag, i), C_op, 4'd0);
      end
      step();
      check($sformatf("%s start fall", tag), C_start, 1'b0);
   endtask

   // Called in the first cycle after C_start falls: result arrives at once,
   // then Unlock (after one ready-wait cycle) and the response.
   task automatic finish_ok(input string tag, input logic [31:0] bid, input logic [31:0] k);
      roundOver = 1'b1;
      maxBid    = bid;
      step();
      roundOver = 1'b0;
      maxBid    = 32'hDEAD_BEEF;
      check({tag, " unlock wait"}, C_op, 4'd0);
      step();
      check({tag, " unlock code"}, C_op, 4'd1);
      check({tag, " unlock key"}, C_data, k);
      step();
      check({tag, " ucheck noop"}, C_op, 4'd0);
      step();
      check({tag, " rsp_valid"}, rsp_valid, 1'b1);
      check({tag, " rsp_status"}, rsp_status, 2'b00);
      check({tag, " rsp_err"}, rsp_err, 2'b00);
      check({tag, " rsp_max_bid"}, rsp_max_bid, bid);
      check({tag, " req_ready in resp"}, req_ready, 1'b0);
   endtask

   task automatic expect_idle(input string tag);
      check({tag, " idle rsp_valid"}, rsp_valid, 1'b0);
      check({tag, " idle busy"}, busy, 1'b0);
      check({tag, " idle req_ready"}, req_ready, 1'b1);
   endtask

   initial begin
      int bad;
      reset_n   = 1'b0;
      req_valid = 1'b0;
      ready     = 1'b1;
      err       = 2'b00;
      roundOver = 1'b0;
      maxBid    = 32'd0;
      present(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) step();
      reset_n = 1'b1;
      step();

      // ---------------- reset state
      check("reset C_op", C_op, 4'd0);
      check("reset C_data", C_data, 32'd0);
      check("reset C_start", C_start, 1'b0);
      check("reset rsp_status", rsp_status, 2'b00);
      check("reset rsp_max_bid", rsp_max_bid, 32'd0);
      expect_idle("reset");

      // ---------------- normal round
      present(100, 200, 300, 3'd7, 15, 1, 32'h0F0F_0F0F, 16'd4);
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      req_x_bal = 32'd999;          // must not leak into LoadX
      check("norm busy", busy, 1'b1);
      check("norm req_ready", req_ready, 1'b0);
      check("norm issue noop", C_op, 4'd0);
      expect_ops("norm", 100, 200, 300, 3'd7, 15, 1, 32'h0F0F_0F0F, 7);
      expect_round("norm", 4);
      finish_ok("norm", 32'd300, 32'h0F0F_0F0F);
      step();
      expect_idle("norm");

      // ---------------- error after SetTimer
      present(11, 22, 33, 3'd5, 9, 2, 32'hA5A5_0001, 16'd3);
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      expect_ops("err", 11, 22, 33, 3'd5, 9, 2, 32'hA5A5_0001, 5);
      err = 2'b11;
      step();
      err = 2'b00;
      check("err rsp_valid", rsp_valid, 1'b1);
      check("err rsp_status", rsp_status, 2'b01);
      check("err rsp_err", rsp_err, 2'b11);
      check("err rsp_max_bid", rsp_max_bid, 32'd0);
      check("err no charge", C_op, 4'd0);
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (C_op !== 4'd0 || C_start !== 1'b0) bad++;
      end
      check("err no lock/start", bad, 0);
      expect_idle("err");

      // ---------------- ready stall from LoadY
      present(5, 6, 7, 3'd1, 8, 3, 32'h1234_5678, 16'd2);
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      expect_ops("stall", 5, 6, 7, 3'd1, 8, 3, 32'h1234_5678, 1);
      ready = 1'b0;
      bad = 0;
      for (int i = 1; i < 16; i++) begin
         step();
         if (C_op !== 4'd0 || rsp_valid !== 1'b0) bad++;
      end
      check("stall bus quiet", bad, 0);
      step();
      check("stall rsp_valid", rsp_valid, 1'b1);
      check("stall rsp_status", rsp_status, 2'b11);
      check("stall rsp_max_bid", rsp_max_bid, 32'd0);
      check("stall no op", C_op, 4'd0);
      ready = 1'b1;
      step();
      expect_idle("stall");

      // ---------------- result timeout
      present(1, 2, 3, 3'd6, 4, 5, 32'hCAFE_0010, 16'd2);
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      expect_ops("rto", 1, 2, 3, 3'd6, 4, 5, 32'hCAFE_0010, 7);
      expect_round("rto", 2);
      bad = 0;
      for (int i = 2; i <= 64; i++) begin
         step();
         if (C_op !== 4'd0 || C_start !== 1'b0 || rsp_valid !== 1'b0) bad++;
      end
      check("rto wait quiet", bad, 0);
      step();
      check("rto unlock wait", C_op, 4'd0);
      step();
      check("rto unlock code", C_op, 4'd1);
      check("rto unlock key", C_data, 32'hCAFE_0010);
      step();
      step();
      check("rto rsp_valid", rsp_valid, 1'b1);
      check("rto rsp_status", rsp_status, 2'b10);
      check("rto rsp_max_bid", rsp_max_bid, 32'd0);
      step();
      expect_idle("rto");

      // ---------------- reset on 2nd C_start cycle
      present(9, 9, 9, 3'd3, 9, 9, 32'h0000_BEEF, 16'd4);
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      expect_ops("rst", 9, 9, 9, 3'd3, 9, 9, 32'h0000_BEEF, 7);
      step();
      check("rst start1", C_start, 1'b1);
      step();
      check("rst start2", C_start, 1'b1);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      check("rst C_start", C_start, 1'b0);
      check("rst C_op", C_op, 4'd0);
      expect_idle("rst");
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
      end
      check("rst no rsp", bad, 0);

      // ---------------- len=0 and back-to-back requests
      present(32'h1111, 32'h2222, 32'h3333, 3'd2, 32'h44, 32'h55, 32'h6666_7777, 16'd0);
      req_valid = 1'b1;
      step();
      check("b2b busy", busy, 1'b1);
      // second request presented immediately and held valid throughout
      present(32'hA1, 32'hA2, 32'hA3, 3'd4, 32'hA4, 32'hA5, 32'hA6A6_A6A6, 16'd3);
      expect_ops("b2b1", 32'h1111, 32'h2222, 32'h3333, 3'd2, 32'h44, 32'h55, 32'h6666_7777, 7);
      expect_round("b2b1", 1);
      finish_ok("b2b1", 32'h77, 32'h6666_7777);
      step();
      expect_idle("b2b gap");
      step();
      req_valid = 1'b0;
      check("b2b2 accepted busy", busy, 1'b1);
      check("b2b2 accepted req_ready", req_ready, 1'b0);
      expect_ops("b2b2", 32'hA1, 32'hA2, 32'hA3, 3'd4, 32'hA4, 32'hA5, 32'hA6A6_A6A6, 7);
      expect_round("b2b2", 3);
      finish_ok("b2b2", 32'h0001_2345, 32'hA6A6_A6A6);
      step();
      expect_idle("b2b2");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
